mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
- Sequential unsigned multiply-accumulate block.
- A one-cycle start pulse captures operands a and b. An iterative shift-add multiplier forms a*b. The product is then added into a running accumulator driven on dout.
- busy marks the operation in flight; its falling edge signals that dout holds the updated sum.
- Used as a low-area MAC in the DFR datapath, where the caller sequences operand pairs one at a time.

Parameters:
- DATA_WIDTH, 32, width of operands a/b, of the internal product and of the accumulator/dout.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- a  input  DATA_WIDTH  unsigned multiplicand; sampled only on the start-accepting edge.
- b  input  DATA_WIDTH  unsigned multiplier; sampled only on the start-accepting edge.
- start  input  1  request pulse; accepted only when idle.
- dout  output  DATA_WIDTH  accumulator value (running sum of products).
- busy  output  1  high while an accepted operation is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, busy=0, dout=0.
  - Operand, partial-product and counter registers cleared.
  - Reset asserted mid-operation aborts the operation; the accumulator is cleared and no partial result is kept.
- States: IDLE, MULT, ACC.
- IDLE, rising edge with start=1:
  - Latch a into multiplicand register and b into multiplier register.
  - Clear product; load counter with DATA_WIDTH.
  - Go to MULT; busy=1 after the same edge.
- MULT, once per cycle:
  - If multiplier LSB=1, product += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter decrements.
  - After DATA_WIDTH cycles go to ACC.
  - No early exit: latency is fixed regardless of operand values.
- ACC, one cycle: dout <= dout + product; busy <= 0; return to IDLE.
- Latency:
  - start sampled at edge N.
  - busy high after N through edge N+DATA_WIDTH+1.
  - dout updates and busy falls on edge N+DATA_WIDTH+1, i.e. busy high for DATA_WIDTH+1 cycles.
- dout is stable whenever busy=0; it changes only on the ACC edge (or reset).
- Arithmetic:
  - Unsigned.
  - Product truncated to low DATA_WIDTH bits.
  - Accumulator wraps modulo 2^DATA_WIDTH, with no saturation and no overflow flag.
- start while busy is ignored (no queueing); a/b changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first idle edge after ACC (one IDLE cycle between operations).
- Zero operands still take the full latency and add 0.
- No clear port: the accumulator is cleared only by reset.

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE, MULT, ACC);
  - default DATA_WIDTH constant;
  - counter width constant = clog2(DATA_WIDTH+1).
- One natural sub-module: seq_multiplier (shift-add core with start/done).
- mac_unit wraps seq_multiplier, adds the accumulator register and the busy/ACC control.

Test Plan:
- Reset: hold rst=0 for 5 cycles, release -> dout=0, busy=0; no busy activity without start.
- Sum of squares: for i=0..9 pulse start with a=b=i, wait for busy fall -> dout after each op equals running sum; final dout=285 (0x11D).
- Latency: single start with a=3, b=7 -> busy high exactly DATA_WIDTH+1 (33) cycles; dout goes 0->21 on the edge busy falls and is unchanged before it.
- Ignore while busy:
  - a=2, b=5 start, then a=100, b=100 start pulse mid-operation -> only +10 accumulated, busy not extended.
  - a/b toggled while busy -> result unaffected.
- Wrap: a=0xFFFFFFFF, b=2 (product truncates to 0xFFFFFFFE) on dout=5 -> dout=0x00000003.
- Async reset mid-op: assert rst=0 between clock edges during MULT -> busy and dout go 0 immediately; next start with a=4, b=4 -> dout=16.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and sizing constants for the multiply-accumulate block.
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CNT_W_DEF      = $clog2(DATA_WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2
    } mac_state_t;

    // Counter must hold the value DATA_WIDTH itself, hence the +1.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// fixed DATA_WIDTH-cycle latency, product truncated to DATA_WIDTH bits.
module seq_multiplier
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] product,
    output logic                  done
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [DATA_WIDTH-1:0] product_q;
    logic [CNT_W-1:0]      cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else if (start) begin
            mcand_q   <= a;
            mplier_q  <= b;
            product_q <= '0;
            cnt_q     <= CNT_LOAD;
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_ONE;
        end
    end

    // Asserted during the final iteration so the caller can leave on that edge.
    assign done    = (cnt_q == CNT_ONE);
    assign product = product_q;

endmodule

// File: rtl/mac_unit.sv
// Sequential unsigned multiply-accumulate: start captures a/b, the shift-add
// core forms a*b, and one ACC cycle adds it into the wrapping accumulator.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; dout stable, busy low
// MULT  | shift-add core iterating, DATA_WIDTH cycles
// ACC   | add product into accumulator, then back to IDLE
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);

    mac_state_t            state_q;
    mac_state_t            state_d;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] product;
    logic                  mult_start;
    logic                  mult_done;

    // Starts arriving while an operation is in flight are simply dropped.
    assign mult_start = (state_q == IDLE) && start;

    seq_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (mult_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MULT;
            MULT:    if (mult_done) state_d = ACC;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (state_q == ACC) begin
            acc_q <= acc_q + product;
        end
    end

    assign dout = acc_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: stimulus pushes expected running sums,
// a monitor pops and compares on every busy falling edge.
module tb_mac_unit;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int TIMEOUT = 200;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start;
    logic [W-1:0] dout;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_acc;

    mac_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .dout  (dout),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: latency, dout stability while busy, and the scoreboard value.
    initial begin : monitor
        bit           prev_busy;
        int           busy_cycles;
        bit           changed;
        logic [W-1:0] dout_at_start;
        prev_busy   = 1'b0;
        busy_cycles = 0;
        changed     = 1'b0;
        dout_at_start = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_busy   = 1'b0;
                busy_cycles = 0;
                changed     = 1'b0;
            end else begin
                if (busy === 1'b1) begin
                    if (!prev_busy) begin
                        dout_at_start = dout;
                        changed       = 1'b0;
                    end else if (dout !== dout_at_start) begin
                        changed = 1'b1;
                    end
                    busy_cycles++;
                end else if (prev_busy) begin
                    check("busy_len", W'(busy_cycles), W'(LAT));
                    check("dout_stable_busy", W'(changed), '0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got %0h expected none", dout);
                    end else begin
                        check("dout_sum", dout, exp_q.pop_front());
                    end
                    busy_cycles = 0;
                end
                prev_busy = (busy === 1'b1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            tests++;
            fails++;
            $display("FAIL timeout_busy: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic push_op(input logic [W-1:0] x, input logic [W-1:0] y);
        model_acc = model_acc + x * y;
        exp_q.push_back(model_acc);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        push_op(x, y);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        model_acc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin : stim
        rst       = 1'b0;
        a         = '0;
        b         = '0;
        start     = 1'b0;
        model_acc = '0;

        repeat (5) @(posedge clk);
        #1;
        check("reset_dout_held", dout, '0);
        check("reset_busy_held", W'(busy), '0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_dout", dout, '0);
        check("reset_busy", W'(busy), '0);
        repeat (5) @(negedge clk);
        check("no_start_busy", W'(busy), '0);

        // Latency: 0 -> 21; monitor verifies 33 busy cycles and stable dout.
        do_op(3, 7);
        wait_idle();
        check("latency_result", dout, 32'd21);

        // Sum of squares 0..9.
        do_reset();
        for (int i = 0; i < 10; i++) do_op(W'(i), W'(i));
        wait_idle();
        check("squares_final", dout, 32'h11D);

        // Start pulse and operand churn while busy must be ignored.
        do_op(2, 5);
        repeat (5) @(negedge clk);
        a = 100; b = 100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
        end
        wait_idle();
        check("ignore_busy", dout, 32'd295);

        // Wrap: 5 + 0xFFFFFFFE -> 3.
        do_reset();
        do_op(5, 1);
        do_op(32'hFFFF_FFFF, 2);
        wait_idle();
        check("wrap", dout, 32'h3);

        // start held high: accepted every LAT+1 cycles; 69 edges admit three ops.
        @(negedge clk);
        a = 1; b = 1; start = 1'b1;
        push_op(1, 1); push_op(1, 1); push_op(1, 1);
        repeat (2 * (LAT + 1) + 1) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        check("held_start", dout, 32'h6);

        // Randomized operands, with zero and full-scale values mixed in.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] x, y;
            case ($urandom_range(0, 3))
                0:       x = '0;
                1:       x = '1;
                default: x = $urandom;
            endcase
            y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            do_op(x, y);
        end
        wait_idle();

        // Asynchronous reset mid-MULT, asserted between clock edges.
        do_op(9, 9);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        model_acc = '0;
        #1;
        check("async_rst_busy", W'(busy), '0);
        check("async_rst_dout", dout, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_op(4, 4);
        wait_idle();
        check("after_reset_op", dout, 32'd16);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
